// File: rtl/bp_pkg.sv
// Shared types for the branch prediction return path: in-flight record,
// resolve-unit FSM states and instruction size.
package bp_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int BP_ADDR_W   = 32;
    localparam int BP_GHR_W    = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bru_state_e;

    // Default-width prediction record; the resolve unit re-declares it at its own widths.
    typedef struct packed {
        logic [BP_ADDR_W-1:0] pc;
        logic                 taken;
        logic [BP_ADDR_W-1:0] target;
        logic [BP_GHR_W-1:0]  ghr;
    } pred_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Prediction/resolution handshakes plus the training and recovery outputs
// of the branch resolve unit.
interface branch_resolve_unit_if #(
    parameter int ADDR_W = 32,
    parameter int GHR_W  = 8
) ();
    logic              pred_valid;
    logic              pred_ready;
    logic [ADDR_W-1:0] pred_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [GHR_W-1:0]  pred_ghr;
    logic              res_valid;
    logic              res_ready;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;
    logic              flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic [GHR_W-1:0]  ghr_restore;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_btb_we;
    logic [15:0]       mispredict_count;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_target, pred_ghr,
               res_valid, res_taken, res_target,
        input  pred_ready, res_ready, flush, redirect_pc, ghr_restore,
               upd_valid, upd_pc, upd_taken, upd_target, upd_btb_we, mispredict_count
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_target, pred_ghr,
               res_valid, res_taken, res_target,
        output pred_ready, res_ready, flush, redirect_pc, ghr_restore,
               upd_valid, upd_pc, upd_taken, upd_target, upd_btb_we, mispredict_count
    );
endinterface

// File: rtl/branch_resolve_unit_inflight_fifo.sv
// In-order FIFO of outstanding predictions with a combinational head read
// and a clear that wipes all entries in one cycle.
module inflight_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  logic clear_i,
    input  T     data_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]   count_q;

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/branch_resolve_unit.sv
// Checks in-flight predictions against execute outcomes in order; emits
// predictor training updates and flush/redirect/GHR repair on mispredict.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 32,
    parameter int GHR_W        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_unit_if.slave bus
);
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              taken;
        logic [ADDR_W-1:0] target;
        logic [GHR_W-1:0]  ghr;
    } entry_t;

    entry_t            head, push_entry;
    logic              full, empty;
    logic              pred_fire, res_fire, mispredict, recover;
    bru_state_e        state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              flush_q, upd_valid_q, upd_btb_we_q, upd_taken_q;
    logic [ADDR_W-1:0] redirect_q, upd_pc_q, upd_target_q;
    logic [GHR_W-1:0]  ghr_restore_q;
    logic [15:0]       mcount_q;

    assign bus.pred_ready = !rst && (state_q == IDLE) && !full;
    assign bus.res_ready  = !rst && (state_q == IDLE) && !empty;
    assign pred_fire  = bus.pred_valid && bus.pred_ready;
    assign res_fire   = bus.res_valid && bus.res_ready;
    // Not-taken outcomes never compare targets; the BTB target only matters when taken.
    assign mispredict = (head.taken != bus.res_taken) ||
                        (bus.res_taken && (head.target != bus.res_target));
    assign recover    = res_fire && mispredict;
    assign push_entry = '{pc: bus.pred_pc, taken: bus.pred_taken,
                          target: bus.pred_target, ghr: bus.pred_ghr};

    // A push that coincides with a mispredict is wrong-path and is dropped.
    inflight_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pred_fire && !recover),
        .pop_i   (res_fire && !mispredict),
        .clear_i (recover),
        .data_i  (push_entry),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: if (recover) begin
                state_d = FLUSH;
                fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
            end
            FLUSH: begin
                if (fcnt_q == '0) state_d = IDLE;
                else              fcnt_d  = fcnt_q - FC_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fcnt_q        <= '0;
            flush_q       <= 1'b0;
            upd_valid_q   <= 1'b0;
            upd_btb_we_q  <= 1'b0;
            upd_taken_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_target_q  <= '0;
            redirect_q    <= '0;
            ghr_restore_q <= '0;
            mcount_q      <= '0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            flush_q      <= recover;
            upd_valid_q  <= res_fire;
            upd_btb_we_q <= res_fire && bus.res_taken;
            if (res_fire) begin
                upd_pc_q     <= head.pc;
                upd_taken_q  <= bus.res_taken;
                upd_target_q <= bus.res_target;
            end
            if (recover) begin
                redirect_q    <= bus.res_taken ? bus.res_target : head.pc + ADDR_W'(INSTR_BYTES);
                ghr_restore_q <= {head.ghr[GHR_W-2:0], bus.res_taken};
                if (mcount_q != 16'hFFFF) mcount_q <= mcount_q + 16'd1;
            end
        end
    end

    assign bus.flush            = flush_q;
    assign bus.redirect_pc      = redirect_q;
    assign bus.ghr_restore      = ghr_restore_q;
    assign bus.upd_valid        = upd_valid_q;
    assign bus.upd_pc           = upd_pc_q;
    assign bus.upd_taken        = upd_taken_q;
    assign bus.upd_target       = upd_target_q;
    assign bus.upd_btb_we       = upd_btb_we_q;
    assign bus.mispredict_count = mcount_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: table of single predict/resolve pairs, then
// hand sequences for flush timing, full/clear and reset during recovery.
module tb_branch_resolve_unit;
    logic clk;
    logic rst;

    branch_resolve_unit_if #(.ADDR_W(32), .GHR_W(8)) bif ();

    branch_resolve_unit #(.DEPTH(8), .ADDR_W(32), .GHR_W(8), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ppc;
        logic        pt;
        logic [31:0] ptgt;
        logic [7:0]  pghr;
        logic        rt;
        logic [31:0] rtgt;
        logic        eflush;
        logic [31:0] eredir;
        logic [7:0]  eghr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        flush;
        logic [31:0] redir;
        logic [7:0]  ghr;
        logic [15:0] mc;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [31:0] last_redir = '0;
    logic [7:0]  last_ghr = '0;
    logic [15:0] mc_exp = '0;
    vec_t        vecs[6];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic void push_exp(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                                     input logic fl, input logic [31:0] rd, input logic [7:0] g);
        exp_t e;
        if (fl) begin
            last_redir = rd;
            last_ghr   = g;
            mc_exp     = mc_exp + 16'd1;
        end
        e = '{pc, t, tg, fl, last_redir, last_ghr, mc_exp};
        sb.push_back(e);
    endfunction

    // Scoreboard: every training pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bif.upd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_upd_valid", 32'(bif.upd_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("upd_pc", bif.upd_pc, e.pc);
                chk("upd_taken", 32'(bif.upd_taken), 32'(e.taken));
                chk("upd_target", bif.upd_target, e.tgt);
                chk("upd_btb_we", 32'(bif.upd_btb_we), 32'(e.taken));
                chk("flush", 32'(bif.flush), 32'(e.flush));
                chk("redirect_pc", bif.redirect_pc, e.redir);
                chk("ghr_restore", 32'(bif.ghr_restore), 32'(e.ghr));
                chk("mispredict_count", 32'(bif.mispredict_count), 32'(e.mc));
            end
        end else if (bif.flush === 1'b1) begin
            chk("flush_without_upd", 32'(bif.flush), 32'(0));
        end
    end

    task automatic do_push(input logic [31:0] pc, input logic t, input logic [31:0] tg, input logic [7:0] g);
        int n = 0;
        @(negedge clk);
        bif.pred_pc = pc; bif.pred_taken = t; bif.pred_target = tg; bif.pred_ghr = g;
        bif.pred_valid = 1'b1;
        while (bif.pred_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            chk("push_timeout", 32'(bif.pred_ready), 32'(1));
            bif.pred_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bif.pred_valid = 1'b0;
    endtask

    task automatic do_res(input logic rt, input logic [31:0] rtg, input logic [31:0] hpc,
                          input logic fl, input logic [31:0] rd, input logic [7:0] g);
        int n = 0;
        @(negedge clk);
        bif.res_taken = rt; bif.res_target = rtg; bif.res_valid = 1'b1;
        while (bif.res_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            chk("res_timeout", 32'(bif.res_ready), 32'(1));
            bif.res_valid = 1'b0;
            return;
        end
        @(posedge clk);
        push_exp(hpc, rt, rtg, fl, rd, g);
        #1 bif.res_valid = 1'b0;
    endtask

    task automatic do_both(input logic [31:0] ppc, input logic [7:0] pg,
                           input logic rt, input logic [31:0] rtg, input logic [31:0] hpc,
                           input logic fl, input logic [31:0] rd, input logic [7:0] g);
        int n = 0;
        @(negedge clk);
        bif.pred_pc = ppc; bif.pred_taken = 1'b0; bif.pred_target = '0; bif.pred_ghr = pg;
        bif.res_taken = rt; bif.res_target = rtg;
        bif.pred_valid = 1'b1; bif.res_valid = 1'b1;
        while (!(bif.pred_ready === 1'b1 && bif.res_ready === 1'b1) && n < 50) begin
            @(negedge clk); n++;
        end
        if (n >= 50) begin
            chk("both_timeout", 32'(bif.res_ready), 32'(1));
            bif.pred_valid = 1'b0; bif.res_valid = 1'b0;
            return;
        end
        @(posedge clk);
        push_exp(hpc, rt, rtg, fl, rd, g);
        #1 begin bif.pred_valid = 1'b0; bif.res_valid = 1'b0; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h100,      1'b0, 32'h0,    8'h00, 1'b0, 32'h0,    1'b0, 32'h0,    8'h00};
        vecs[1] = '{32'h200,      1'b0, 32'h0,    8'h5A, 1'b1, 32'h340,  1'b1, 32'h340,  8'hB5};
        vecs[2] = '{32'h10,       1'b1, 32'h80,   8'h81, 1'b1, 32'h90,   1'b1, 32'h90,   8'h03};
        vecs[3] = '{32'hFFFFFFFC, 1'b1, 32'h1000, 8'hFF, 1'b0, 32'h1234, 1'b1, 32'h0,    8'hFE};
        vecs[4] = '{32'h400,      1'b1, 32'h800,  8'h3C, 1'b1, 32'h800,  1'b0, 32'h0,    8'h00};
        vecs[5] = '{32'h500,      1'b0, 32'h999,  8'h12, 1'b0, 32'h111,  1'b0, 32'h0,    8'h00};

        rst = 1'b1;
        bif.pred_valid = 1'b0; bif.pred_pc = '0; bif.pred_taken = 1'b0;
        bif.pred_target = '0; bif.pred_ghr = '0;
        bif.res_valid = 1'b0; bif.res_taken = 1'b0; bif.res_target = '0;
        repeat (2) @(negedge clk);
        chk("rst_flush", 32'(bif.flush), 32'(0));
        chk("rst_upd_valid", 32'(bif.upd_valid), 32'(0));
        chk("rst_upd_btb_we", 32'(bif.upd_btb_we), 32'(0));
        chk("rst_redirect", bif.redirect_pc, 32'h0);
        chk("rst_ghr", 32'(bif.ghr_restore), 32'(0));
        chk("rst_upd_pc", bif.upd_pc, 32'h0);
        chk("rst_mc", 32'(bif.mispredict_count), 32'(0));
        chk("rst_pred_ready_low", 32'(bif.pred_ready), 32'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_pred_ready", 32'(bif.pred_ready), 32'(1));
        chk("post_rst_res_ready", 32'(bif.res_ready), 32'(0));

        for (int i = 0; i < 6; i++) begin
            do_push(vecs[i].ppc, vecs[i].pt, vecs[i].ptgt, vecs[i].pghr);
            do_res(vecs[i].rt, vecs[i].rtgt, vecs[i].ppc, vecs[i].eflush, vecs[i].eredir, vecs[i].eghr);
        end

        // Ready stays low for exactly FLUSH_CYCLES after the mispredict handshake.
        do_push(32'h200, 1'b0, 32'h0, 8'h5A);
        do_res(1'b1, 32'h340, 32'h200, 1'b1, 32'h340, 8'hB5);
        @(negedge clk);
        chk("flush1_pred_ready", 32'(bif.pred_ready), 32'(0));
        chk("flush1_res_ready", 32'(bif.res_ready), 32'(0));
        @(negedge clk);
        chk("flush2_pred_ready", 32'(bif.pred_ready), 32'(0));
        chk("flush2_res_ready", 32'(bif.res_ready), 32'(0));
        @(negedge clk);
        chk("recover_pred_ready", 32'(bif.pred_ready), 32'(1));
        chk("recover_res_ready", 32'(bif.res_ready), 32'(0));

        // Fill, push+pop at count 7, refill, then mispredict with a concurrent push.
        for (int i = 0; i < 8; i++) do_push(32'h1000 + 32'(i * 4), 1'b0, 32'h0, 8'(i));
        @(negedge clk);
        chk("full_pred_ready", 32'(bif.pred_ready), 32'(0));
        chk("full_res_ready", 32'(bif.res_ready), 32'(1));
        do_res(1'b0, 32'h0, 32'h1000, 1'b0, 32'h0, 8'h00);
        do_both(32'h1020, 8'h08, 1'b0, 32'h0, 32'h1004, 1'b0, 32'h0, 8'h00);
        @(negedge clk);
        chk("cnt7_pred_ready", 32'(bif.pred_ready), 32'(1));
        do_push(32'h1024, 1'b0, 32'h0, 8'h09);
        @(negedge clk);
        chk("refull_pred_ready", 32'(bif.pred_ready), 32'(0));
        do_res(1'b0, 32'h0, 32'h1008, 1'b0, 32'h0, 8'h00);
        do_both(32'h1028, 8'h0A, 1'b1, 32'h2000, 32'h100C, 1'b1, 32'h2000, 8'h07);
        repeat (3) @(negedge clk);
        chk("cleared_res_ready", 32'(bif.res_ready), 32'(0));
        chk("cleared_pred_ready", 32'(bif.pred_ready), 32'(1));

        // Reset while recovering from a mispredict.
        do_push(32'h300, 1'b0, 32'h0, 8'h11);
        do_res(1'b1, 32'h500, 32'h300, 1'b1, 32'h500, 8'h23);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_flush", 32'(bif.flush), 32'(0));
        chk("midrst_upd_valid", 32'(bif.upd_valid), 32'(0));
        chk("midrst_mc", 32'(bif.mispredict_count), 32'(0));
        chk("midrst_redirect", bif.redirect_pc, 32'h0);
        chk("midrst_pred_ready_low", 32'(bif.pred_ready), 32'(0));
        rst = 1'b0;
        mc_exp = '0; last_redir = '0; last_ghr = '0;
        #1;
        chk("midrst_pred_ready", 32'(bif.pred_ready), 32'(1));
        chk("midrst_res_ready", 32'(bif.res_ready), 32'(0));

        do_push(32'h40, 1'b1, 32'h80, 8'h80);
        do_res(1'b0, 32'h0, 32'h40, 1'b1, 32'h44, 8'h00);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
